// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_pkg
// Purpose  : Shared types and constants for the PC sequencer: the state
//            encoding, the instruction/address word width, the sequential PC
//            step and the alignment mask applied to branch targets.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

  localparam int c_word_w = 16;

  // Instructions are 16-bit halfwords, so sequential fetch steps by 2 bytes.
  localparam logic [c_word_w-1:0] c_pc_inc = 16'd2;

  // Clears bit 0 of a branch target when misaligned targets are not trapped.
  localparam logic [c_word_w-1:0] c_align_mask = 16'hFFFE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_t;

endpackage : pc_sequencer_pkg
`default_nettype wire

// File: rtl/pc_sequencer_increment.sv
`default_nettype none
// ============================================================================
// Module   : pc_increment
// Purpose  : Sequential next-PC adder. Wraps modulo 2^16 (16'hFFFE -> 16'h0000)
//            with no carry-out.
// Ports    : i_pc      in  16  current PC
//            o_pc_next out 16  i_pc + 2
// Revision : 1.0 - initial release
// ============================================================================
module pc_increment
  import pc_sequencer_pkg::*;
(
  input  logic [c_word_w-1:0] i_pc,
  output logic [c_word_w-1:0] o_pc_next
);

  // Sum is truncated to the word width; the carry is intentionally dropped.
  assign o_pc_next = i_pc + c_pc_inc;

endmodule : pc_increment
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Instruction fetch sequencer. Requests an instruction at the
//            current fetch address, registers it with its PC for decode,
//            honours decode stalls, and picks the next fetch address from a
//            branch target or PC+2. Halt parks the block until reset.
// Config   : PC_SEQ_TRAP_EN - when defined, an accepted branch to an odd
//            target pulses trap and redirects fetch to TRAP_VECTOR. When not
//            defined, target bit 0 is cleared and trap is tied low.
// Ports    : clk           in  1   clock, rising edge
//            rst_n         in  1   asynchronous active-low reset
//            fetch_req     out 1   instruction-memory read request
//            fetch_addr    out 16  read address (internal fetch PC)
//            fetch_ack     in  1   instr_in valid this cycle
//            instr_in      in  16  instruction word from memory
//            instr         out 16  registered instruction for decode
//            instr_valid   out 1   instr/pc valid for decode
//            pc            out 16  address of instr
//            stall         in  1   decode cannot accept instr
//            branch        in  1   redirect fetch to branch_target
//            branch_target in  16  redirect address
//            halt          in  1   stop after the current instruction
//            trap          out 1   one-cycle misaligned-target pulse
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [c_word_w-1:0] RESET_VECTOR = 16'h0000,
  parameter logic [c_word_w-1:0] TRAP_VECTOR  = 16'h0004
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                fetch_req,
  output logic [c_word_w-1:0] fetch_addr,
  input  logic                fetch_ack,
  input  logic [c_word_w-1:0] instr_in,
  output logic [c_word_w-1:0] instr,
  output logic                instr_valid,
  output logic [c_word_w-1:0] pc,
  input  logic                stall,
  input  logic                branch,
  input  logic [c_word_w-1:0] branch_target,
  input  logic                halt,
  output logic                trap
);

  state_t              r_state;
  state_t              w_state_next;
  logic [c_word_w-1:0] r_fetch_addr;
  logic [c_word_w-1:0] r_pc;
  logic [c_word_w-1:0] r_instr;
  logic [c_word_w-1:0] w_pc_plus2;
  logic [c_word_w-1:0] w_redirect;
  logic                w_fetch_done;
  logic                w_issue_go;
  logic                w_take_branch;
  logic                w_misaligned;

  // The only arithmetic on the PC lives in this instance.
  pc_increment u_pc_increment (
    .i_pc      (r_pc),
    .o_pc_next (w_pc_plus2)
  );

  assign w_fetch_done  = (r_state == FETCH) && fetch_ack;
  // Stall freezes the issue slot, so branch/halt only count once it drops.
  assign w_issue_go    = (r_state == ISSUE) && !stall;
  // Halt outranks branch: a simultaneous branch is simply discarded.
  assign w_take_branch = w_issue_go && !halt && branch;

`ifdef PC_SEQ_TRAP_EN
  logic r_trap;

  assign w_misaligned = branch_target[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trap <= 1'b0;
    end else begin
      r_trap <= w_take_branch && w_misaligned;
    end
  end

  assign trap = r_trap;
`else
  assign w_misaligned = 1'b0;
  assign trap         = 1'b0;
`endif

  assign w_redirect = w_misaligned ? TRAP_VECTOR : (branch_target & c_align_mask);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = FETCH;
      FETCH:   if (fetch_ack) w_state_next = ISSUE;
      ISSUE:   if (!stall) w_state_next = halt ? HALTED : FETCH;
      HALTED:  w_state_next = HALTED;
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_addr <= RESET_VECTOR;
      r_pc         <= RESET_VECTOR;
      r_instr      <= '0;
    end else begin
      if (w_fetch_done) begin
        r_instr <= instr_in;
        r_pc    <= r_fetch_addr;
      end
      if (w_issue_go && !halt) begin
        r_fetch_addr <= w_take_branch ? w_redirect : w_pc_plus2;
      end
    end
  end

  assign fetch_req   = (r_state == FETCH);
  assign instr_valid = (r_state == ISSUE);
  assign fetch_addr  = r_fetch_addr;
  assign pc          = r_pc;
  assign instr       = r_instr;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer. Accepted fetches push the
//            expected {pc, instr} into a scoreboard; the issue cycle pops and
//            compares. Build with PC_SEQ_TRAP_EN to cover the trap variant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam logic [15:0] c_rv = 16'h0000;
  localparam logic [15:0] c_tv = 16'h0004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack = 1'b0;
  logic [15:0] instr_in = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [15:0] branch_target = '0;
  logic        halt = 1'b0;
  logic        trap;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  pc_sequencer #(
    .RESET_VECTOR (c_rv),
    .TRAP_VECTOR  (c_tv)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_ack     (fetch_ack),
    .instr_in      (instr_in),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .stall         (stall),
    .branch        (branch),
    .branch_target (branch_target),
    .halt          (halt),
    .trap          (trap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first FETCH cycle (one IDLE cycle after release).
  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; branch = 1'b0; halt = 1'b0;
    fetch_ack = 1'b0; branch_target = '0; instr_in = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    sb.delete();
  endtask

  // Acknowledge the current fetch with data and record what decode must see.
  task automatic accept(input logic [15:0] exp_pc, input logic [15:0] data);
    fetch_ack = 1'b1;
    instr_in  = data;
    sb.push_back({exp_pc, data});
    tick();
    fetch_ack = 1'b0;
  endtask

  task automatic pop_expected(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    e  = ok ? sb.pop_front() : '0;
  endtask

  task automatic test_reset();
    exp_t e; bit ok;
    do_reset();
    accept(16'h0000, 16'h1111);
    pop_expected(e, ok);
    vectors++;
    if (!ok || instr_valid !== 1'b1 || pc !== e.pc || instr !== e.instr) begin
      miscompares++;
      $display("FAIL reset_first_issue: valid=%b pc=%h instr=%h required valid=1 pc=%h instr=%h",
               instr_valid, pc, instr, e.pc, e.instr);
    end
    branch = 1'b1; branch_target = 16'h0040;
    tick();
    branch = 1'b0;
    accept(16'h0040, 16'hBEEF);
    pop_expected(e, ok);
    vectors++;
    if (!ok || pc !== e.pc || instr !== e.instr) begin
      miscompares++;
      $display("FAIL reset_branch_issue: pc=%h instr=%h required pc=%h instr=%h", pc, instr, e.pc, e.instr);
    end
    stall = 1'b1;
    tick();
    #2 rst_n = 1'b0;   // mid-cycle: values must change without a clock edge
    #1;
    vectors++;
    if (fetch_req !== 1'b0 || instr_valid !== 1'b0 || trap !== 1'b0 ||
        fetch_addr !== c_rv || pc !== c_rv || instr !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_async_values: req=%b valid=%b trap=%b faddr=%h pc=%h instr=%h required 0 0 0 %h %h 0000",
               fetch_req, instr_valid, trap, fetch_addr, pc, instr, c_rv, c_rv);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++;
    if (fetch_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_cycle: fetch_req=%b required 0", fetch_req);
    end
    tick();
    vectors++;
    if (fetch_req !== 1'b1 || fetch_addr !== c_rv) begin
      miscompares++;
      $display("FAIL reset_first_fetch: req=%b faddr=%h required 1 %h", fetch_req, fetch_addr, c_rv);
    end
  endtask

  task automatic test_sequential();
    exp_t e; bit ok;
    logic [15:0] exp_addr;
    logic        prev_valid;
    do_reset();
    exp_addr   = c_rv;
    prev_valid = 1'b0;
    fetch_ack  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (fetch_req === 1'b1) begin
        vectors++;
        if (fetch_addr !== exp_addr) begin
          miscompares++;
          $display("FAIL seq_fetch_addr: faddr=%h required %h", fetch_addr, exp_addr);
        end
        instr_in = exp_addr ^ 16'h3C00;
        sb.push_back({exp_addr, exp_addr ^ 16'h3C00});
        exp_addr = exp_addr + 16'd2;
      end else begin
        pop_expected(e, ok);
        vectors++;
        if (!ok || instr_valid !== 1'b1 || pc !== e.pc || instr !== e.instr) begin
          miscompares++;
          $display("FAIL seq_issue: valid=%b pc=%h instr=%h required valid=1 pc=%h instr=%h",
                   instr_valid, pc, instr, e.pc, e.instr);
        end
      end
      tick();
      vectors++;
      if (instr_valid === prev_valid) begin
        miscompares++;
        $display("FAIL seq_valid_toggle: instr_valid=%b required %b", instr_valid, ~prev_valid);
      end
      prev_valid = instr_valid;
    end
    fetch_ack = 1'b0;
  endtask

  task automatic test_ack_delay();
    exp_t e; bit ok;
    int req_cycles;
    do_reset();
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (fetch_req === 1'b1) req_cycles++;
      tick();
    end
    if (fetch_req === 1'b1) req_cycles++;
    accept(16'h0000, 16'hA5A5);
    vectors++;
    if (req_cycles != 4) begin
      miscompares++;
      $display("FAIL ack_delay_req_cycles: saw %0d required 4", req_cycles);
    end
    pop_expected(e, ok);
    vectors++;
    if (!ok || instr_valid !== 1'b1 || pc !== e.pc || instr !== e.instr) begin
      miscompares++;
      $display("FAIL ack_delay_issue: valid=%b pc=%h instr=%h required valid=1 pc=%h instr=%h",
               instr_valid, pc, instr, e.pc, e.instr);
    end
    // An ack outside FETCH must not disturb the held instruction.
    stall = 1'b1; fetch_ack = 1'b1; instr_in = 16'hFFFF;
    tick(); tick();
    vectors++;
    if (instr !== 16'hA5A5 || instr_valid !== 1'b1 || fetch_req !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_outside_fetch: instr=%h valid=%b req=%b required A5A5 1 0", instr, instr_valid, fetch_req);
    end
    fetch_ack = 1'b0; stall = 1'b0;
    tick();
    fetch_ack = 1'b1; instr_in = 16'h7777;
    #2 rst_n = 1'b0;   // abort a fetch before its acknowledge is clocked
    #1;
    vectors++;
    if (instr !== 16'h0000 || pc !== c_rv || fetch_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_fetch: instr=%h pc=%h req=%b required 0000 %h 0", instr, pc, fetch_req, c_rv);
    end
    fetch_ack = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_stall();
    exp_t e; bit ok;
    do_reset();
    accept(16'h0000, 16'h0001);
    pop_expected(e, ok);
    branch = 1'b1; branch_target = 16'h0010;
    tick();
    branch = 1'b0;
    vectors++;
    if (fetch_req !== 1'b1 || fetch_addr !== 16'h0010) begin
      miscompares++;
      $display("FAIL stall_branch_target: req=%b faddr=%h required 1 0010", fetch_req, fetch_addr);
    end
    accept(16'h0010, 16'h1234);
    pop_expected(e, ok);
    vectors++;
    if (!ok || pc !== e.pc || instr !== e.instr) begin
      miscompares++;
      $display("FAIL stall_issue: pc=%h instr=%h required pc=%h instr=%h", pc, instr, e.pc, e.instr);
    end
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      branch = (i == 2); branch_target = 16'h0300;
      tick();
      vectors++;
      if (instr_valid !== 1'b1 || pc !== 16'h0010 || instr !== 16'h1234 || fetch_req !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold: valid=%b pc=%h instr=%h req=%b required 1 0010 1234 0",
                 instr_valid, pc, instr, fetch_req);
      end
    end
    branch = 1'b0; stall = 1'b0;
    tick();
    vectors++;
    if (fetch_req !== 1'b1 || fetch_addr !== 16'h0012) begin
      miscompares++;
      $display("FAIL stall_release: req=%b faddr=%h required 1 0012", fetch_req, fetch_addr);
    end
  endtask

  task automatic test_halt_branch();
    exp_t e; bit ok;
    do_reset();
    accept(16'h0000, 16'h2222);
    pop_expected(e, ok);
    branch = 1'b1; branch_target = 16'h0100; halt = 1'b1;
    tick();
    branch = 1'b0; halt = 1'b0; fetch_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (fetch_req !== 1'b0 || instr_valid !== 1'b0 || fetch_addr === 16'h0100) begin
        miscompares++;
        $display("FAIL halt_over_branch: req=%b valid=%b faddr=%h required 0 0 not-0100",
                 fetch_req, instr_valid, fetch_addr);
      end
      tick();
    end
    fetch_ack = 1'b0;
  endtask

  task automatic test_wrap();
    exp_t e; bit ok;
    do_reset();
    accept(16'h0000, 16'h3333);
    pop_expected(e, ok);
    branch = 1'b1; branch_target = 16'hFFFE;
    tick();
    branch = 1'b0;
    accept(16'hFFFE, 16'h4444);
    pop_expected(e, ok);
    vectors++;
    if (!ok || pc !== e.pc || instr !== e.instr) begin
      miscompares++;
      $display("FAIL wrap_issue: pc=%h instr=%h required pc=%h instr=%h", pc, instr, e.pc, e.instr);
    end
    tick();
    vectors++;
    if (fetch_req !== 1'b1 || fetch_addr !== 16'h0000) begin
      miscompares++;
      $display("FAIL wrap_next_addr: req=%b faddr=%h required 1 0000", fetch_req, fetch_addr);
    end
  endtask

  task automatic test_trap();
    exp_t e; bit ok;
    logic [15:0] exp_addr;
    logic        exp_trap;
`ifdef PC_SEQ_TRAP_EN
    exp_addr = c_tv;
    exp_trap = 1'b1;
`else
    exp_addr = 16'h0202;
    exp_trap = 1'b0;
`endif
    do_reset();
    accept(16'h0000, 16'h5555);
    pop_expected(e, ok);
    branch = 1'b1; branch_target = 16'h0203;
    tick();
    branch = 1'b0;
    vectors++;
    if (trap !== exp_trap || fetch_addr !== exp_addr) begin
      miscompares++;
      $display("FAIL trap_redirect: trap=%b faddr=%h required %b %h", trap, fetch_addr, exp_trap, exp_addr);
    end
    accept(exp_addr, 16'h6666);
    vectors++;
    if (trap !== 1'b0) begin
      miscompares++;
      $display("FAIL trap_one_cycle: trap=%b required 0", trap);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ack_delay();
    test_stall();
    test_halt_branch();
    test_wrap();
    test_trap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_pc_sequencer
`default_nettype wire
